// File: rtl/traffic_input_conditioner.sv
// Input front-end for the traffic-light controller: synchronises and debounces the car
// sensors and push-buttons, turns button presses into single pulses, and generates the step tick.
module traffic_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_DIV        = 10
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_sens_a,
    input  logic i_sens_b,
    input  logic i_btn_parade,
    input  logic i_btn_stop,
    output logic o_ta,
    output logic o_tb,
    output logic o_perad,
    output logic o_stop,
    output logic o_tick
);

    localparam int CH_A    = 0;
    localparam int CH_B    = 1;
    localparam int CH_PAR  = 2;
    localparam int CH_STOP = 3;

    localparam logic [7:0]  CNT_LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
        $error("traffic_input_conditioner: DEBOUNCE_CYCLES out of range 2..255");
    end
    if (TICK_DIV < 2 || TICK_DIV > 65535) begin : g_bad_tick
        $error("traffic_input_conditioner: TICK_DIV out of range 2..65535");
    end

    logic [3:0]  raw;
    logic [3:0]  sync_s1;
    logic [3:0]  sync_s2;
    logic [3:0]  stable;
    logic [1:0]  btn_stable_d;
    logic        par_rise;
    logic        stop_rise;
    logic        perad_q;
    logic        stop_q;
    logic [15:0] tcnt;
    logic        tick_q;

    assign raw = {i_btn_stop, i_btn_parade, i_sens_b, i_sens_a};

    // Stage boundary: two-flop synchroniser, raw -> s1 -> s2
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            sync_s1 <= raw;
            sync_s2 <= sync_s1;
        end
    end

    // Stage boundary: per-channel debounce; any return to the stable level restarts the count
    for (genvar g = 0; g < 4; g++) begin : g_deb
        logic [7:0] cnt;
        logic       stab;

        always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
                cnt  <= '0;
                stab <= 1'b0;
            end else if (sync_s2[g] == stab) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stab <= sync_s2[g];
                cnt  <= '0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end

        assign stable[g] = stab;
    end

    assign par_rise  = stable[CH_PAR]  & ~btn_stable_d[0];
    assign stop_rise = stable[CH_STOP] & ~btn_stable_d[1];

    // Stage boundary: press pulses; a simultaneous parade press is dropped in favour of stop
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            btn_stable_d <= '0;
            perad_q      <= 1'b0;
            stop_q       <= 1'b0;
        end else begin
            btn_stable_d <= {stable[CH_STOP], stable[CH_PAR]};
            stop_q       <= stop_rise;
            perad_q      <= par_rise & ~stop_rise;
        end
    end

    // Stage boundary: free-running tick divider, strobe follows the wrap edge
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            tcnt   <= '0;
            tick_q <= 1'b0;
        end else if (tcnt == TICK_LAST) begin
            tcnt   <= '0;
            tick_q <= 1'b1;
        end else begin
            tcnt   <= tcnt + 16'd1;
            tick_q <= 1'b0;
        end
    end

    assign o_ta    = stable[CH_A];
    assign o_tb    = stable[CH_B];
    assign o_perad = perad_q;
    assign o_stop  = stop_q;
    assign o_tick  = tick_q;

endmodule

// File: tb/tb_traffic_input_conditioner.sv
// Directed bench for traffic_input_conditioner at default parameters (DEBOUNCE_CYCLES=4, TICK_DIV=10).
module tb_traffic_input_conditioner;

    logic clk;
    logic rstn;
    logic sens_a;
    logic sens_b;
    logic btn_parade;
    logic btn_stop;
    logic ta;
    logic tb;
    logic perad;
    logic stop;
    logic tick;

    int tests;
    int failures;

    traffic_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .TICK_DIV(10)
    ) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_sens_a    (sens_a),
        .i_sens_b    (sens_b),
        .i_btn_parade(btn_parade),
        .i_btn_stop  (btn_stop),
        .o_ta        (ta),
        .o_tb        (tb),
        .o_perad     (perad),
        .o_stop      (stop),
        .o_tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ta"},    ta,    1'b0);
        check({tag, "_tb"},    tb,    1'b0);
        check({tag, "_perad"}, perad, 1'b0);
        check({tag, "_stop"},  stop,  1'b0);
        check({tag, "_tick"},  tick,  1'b0);
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    int tick_cnt;
    int first_tick;
    int last_tick;

    initial begin
        tests      = 0;
        failures   = 0;
        rstn       = 1'b0;
        sens_a     = 1'b0;
        sens_b     = 1'b0;
        btn_parade = 1'b0;
        btn_stop   = 1'b0;

        // Reset state, then release one time unit after an edge
        #1;
        check_all_zero("rst_init");
        repeat (3) edge_sample();
        check_all_zero("rst_held");
        rstn = 1'b1;

        // Tick: ten strobes over 100 edges, first after edge 10, spaced by 10
        tick_cnt   = 0;
        first_tick = 0;
        last_tick  = 0;
        for (int e = 1; e <= 100; e++) begin
            edge_sample();
            if (tick) begin
                if (tick_cnt == 0) first_tick = e;
                else check_int("tick_gap", e - last_tick, 10);
                last_tick = e;
                tick_cnt++;
            end
        end
        check_int("tick_count", tick_cnt, 10);
        check_int("tick_first", first_tick, 10);

        // Sensor A rise and fall, six edges each way
        sens_a = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            edge_sample();
            check("sens_a_rise", ta, (i >= 6));
        end
        sens_a = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            edge_sample();
            check("sens_a_fall", ta, (i < 6));
        end

        // Sensor B bounce: high 3, low 1, high 3, low -> never accepted
        for (int i = 1; i <= 16; i++) begin
            sens_b = (i <= 3) || (i >= 5 && i <= 7);
            edge_sample();
            check("bounce_tb", tb, 1'b0);
        end
        sens_b = 1'b0;

        // Parade held 20 cycles: one pulse on edge 7, none on release
        btn_parade = 1'b1;
        for (int i = 1; i <= 34; i++) begin
            edge_sample();
            check("parade_pulse", perad, (i == 7));
            check("parade_nostop", stop, 1'b0);
            if (i == 20) btn_parade = 1'b0;
        end

        // Simultaneous press: stop wins, parade dropped
        btn_parade = 1'b1;
        btn_stop   = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            edge_sample();
            check("prio_stop", stop, (i == 7));
            check("prio_perad", perad, 1'b0);
        end
        btn_parade = 1'b0;
        btn_stop   = 1'b0;
        repeat (10) edge_sample();

        // Async reset mid-cycle with all inputs high
        sens_a     = 1'b1;
        sens_b     = 1'b1;
        btn_parade = 1'b1;
        btn_stop   = 1'b1;
        repeat (10) edge_sample();
        check("pre_rst_ta", ta, 1'b1);
        check("pre_rst_tb", tb, 1'b1);
        #3;
        rstn = 1'b0;
        #1;
        check_all_zero("rst_async");
        repeat (2) edge_sample();
        check_all_zero("rst_hold2");
        rstn = 1'b1;

        // Inputs held through reset are seen as fresh rises
        for (int i = 1; i <= 12; i++) begin
            edge_sample();
            check("post_rst_ta", ta, (i >= 6));
            check("post_rst_tb", tb, (i >= 6));
            check("post_rst_stop", stop, (i == 7));
            check("post_rst_perad", perad, 1'b0);
            check("post_rst_tick", tick, (i == 10));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
